// File: rtl/dec_arb_pkg.sv
// rtl/dec_arb_pkg.sv - shared sizes and state type for the round-robin decoder arbiter
package dec_arb_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dec_gnt_decoder_4to16.sv
// rtl/dec_gnt_decoder_4to16.sv - combinational 4-to-16 one-hot select decoder with enable
//
// Ports:
//   i_idx     in   4   index to decode
//   i_en      in   1   enable; output is all zero when low
//   o_onehot  out  16  one-hot decode of i_idx, gated by i_en
module dec_gnt_decoder_4to16
    import dec_arb_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// rtl/dec_rr_arbiter.sv - round-robin arbiter sharing one 4-to-16 select decoder among 16 requesters
//
// Grants one requester at a time, holds the grant until release, then leaves a
// one-cycle gap with no grant (break-before-make) before the next grant.
//
// Optional feature macro: DEC_ARB_TIMEOUT_EN
//   defined   - a grant held for MAX_HOLD BUSY cycles is forcibly released and
//               o_timeout pulses for that cycle
//   undefined - no hold counter; o_timeout is constant 0
//
// Ports:
//   i_clk         in   1   clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   i_req         in   16  request vector, bit i = requester i
//   i_release     in   1   owner done; ignored when no grant is active
//   o_gnt_valid   out  1   a grant is active
//   o_gnt_idx     out  4   registered index of the granted requester
//   o_gnt_onehot  out  16  decoded grant, all zero when o_gnt_valid=0
//   o_timeout     out  1   one-cycle pulse on forced release
module dec_rr_arbiter
    import dec_arb_pkg::*;
`ifdef DEC_ARB_TIMEOUT_EN
#(
    parameter int unsigned MAX_HOLD = 8
)
`endif
(
    input  logic             i_clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_release,
    output logic             o_gnt_valid,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic [N_REQ-1:0] o_gnt_onehot,
    output logic             o_timeout
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_pick;
    logic             w_any_req;
    logic             w_force;

    // Rotate the request vector so ptr lands at bit 0, take the lowest set bit,
    // then add ptr back. Index arithmetic wraps naturally in IDX_W bits.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        logic               found;
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!found && rot[i]) begin
                off   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return ptr + off;
    endfunction

    assign w_pick    = rr_pick(i_req, r_ptr);
    assign w_any_req = |i_req;

`ifdef DEC_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] r_hold_cnt;

    // Timeout is flagged on the last allowed BUSY cycle even when release
    // arrives at the same time; both still count as a single release.
    assign w_force   = (r_state == BUSY) && (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign o_timeout = w_force;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (r_state != BUSY) begin
            r_hold_cnt <= '0;
        end else if (!w_force) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_force   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_idx_nxt = r_gnt_idx;
        w_ptr_nxt     = r_ptr;
        case (r_state)
            IDLE, GAP: begin
                if (w_any_req) begin
                    w_gnt_idx_nxt = w_pick;
                    w_state_nxt   = BUSY;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            BUSY: begin
                if (i_release || w_force) begin
                    w_ptr_nxt   = r_gnt_idx + 1'b1;
                    w_state_nxt = GAP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt_idx <= '0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    // Valid is decoded from state so an async reset clears every output at once.
    assign o_gnt_valid = (r_state == BUSY);
    assign o_gnt_idx   = r_gnt_idx;

    dec_gnt_decoder_4to16 u_dec (
        .i_idx    (r_gnt_idx),
        .i_en     (o_gnt_valid),
        .o_onehot (o_gnt_onehot)
    );

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// tb/tb_dec_rr_arbiter.sv - directed self-checking bench for dec_rr_arbiter
module tb_dec_rr_arbiter;

    logic        i_clk;
    logic        rst;
    logic [15:0] i_req;
    logic        i_release;
    logic        o_gnt_valid;
    logic [3:0]  o_gnt_idx;
    logic [15:0] o_gnt_onehot;
    logic        o_timeout;

    int checks   = 0;
    int failures = 0;

    dec_rr_arbiter dut (
        .i_clk        (i_clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_release    (i_release),
        .o_gnt_valid  (o_gnt_valid),
        .o_gnt_idx    (o_gnt_idx),
        .o_gnt_onehot (o_gnt_onehot),
        .o_timeout    (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] idx);
        logic [15:0] oh;
        oh = 16'h0001 << idx;
        chk({tag, "_valid"},  32'(o_gnt_valid),  32'h1);
        chk({tag, "_idx"},    32'(o_gnt_idx),    32'(idx));
        chk({tag, "_onehot"}, 32'(o_gnt_onehot), 32'(oh));
    endtask

    task automatic chk_gap(input string tag, input logic [3:0] held_idx);
        chk({tag, "_gap_valid"},  32'(o_gnt_valid),  32'h0);
        chk({tag, "_gap_onehot"}, 32'(o_gnt_onehot), 32'h0);
        chk({tag, "_gap_idx"},    32'(o_gnt_idx),    32'(held_idx));
    endtask

    // Pulse release for one cycle while the grant at cur_idx is active, check
    // the gap, then check the following grant.
    task automatic release_to(input string tag, input logic [3:0] cur_idx, input logic [3:0] nxt_idx);
        i_release = 1'b1;
        @(negedge i_clk);
        i_release = 1'b0;
        chk_gap(tag, cur_idx);
        @(negedge i_clk);
        chk_grant(tag, nxt_idx);
    endtask

    initial begin
        logic [3:0] e;
        rst       = 1'b1;
        i_req     = 16'h0000;
        i_release = 1'b0;
        repeat (2) @(negedge i_clk);

        chk("rst_valid",   32'(o_gnt_valid),  32'h0);
        chk("rst_idx",     32'(o_gnt_idx),    32'h0);
        chk("rst_onehot",  32'(o_gnt_onehot), 32'h0);
        chk("rst_timeout", 32'(o_timeout),    32'h0);
        rst = 1'b0;
        @(negedge i_clk);
        chk("idle_novalid", 32'(o_gnt_valid), 32'h0);

        // 1: single requester 0, one-cycle latency
        i_req = 16'h0001;
        #1;
        chk("t1_before_edge", 32'(o_gnt_valid), 32'h0);
        @(negedge i_clk);
        chk_grant("t1", 4'd0);

        // 2: all requesting, release every BUSY cycle -> 1..15, 0
        i_req = 16'hFFFF;
        e = 4'd0;
        for (int k = 0; k < 16; k++) begin
            release_to("t2", e, e + 4'd1);
            e = e + 4'd1;
        end

        // 3: reach idx 15, then pointer wrap to 0, then 15 again
        i_req = 16'h8000;
        release_to("t3a", 4'd0, 4'd15);
        i_req = 16'h8001;
        release_to("t3b", 4'd15, 4'd0);
        release_to("t3c", 4'd0, 4'd15);

        // 4: lone requester 5 re-granted after a single gap cycle
        i_req = 16'h0020;
        release_to("t4a", 4'd15, 4'd5);
        release_to("t4b", 4'd5, 4'd5);
        chk("t4_onehot", 32'(o_gnt_onehot), 32'h0000_0020);

        // owner dropping its request while BUSY changes nothing
        i_req = 16'h0000;
        @(negedge i_clk);
        chk_grant("t4_drop", 4'd5);

        // 5: async reset mid-BUSY at idx 9
        i_req = 16'h0200;
        release_to("t5", 4'd5, 4'd9);
        @(posedge i_clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid",   32'(o_gnt_valid),  32'h0);
        chk("t5_async_idx",     32'(o_gnt_idx),    32'h0);
        chk("t5_async_onehot",  32'(o_gnt_onehot), 32'h0);
        chk("t5_async_timeout", 32'(o_timeout),    32'h0);
        @(negedge i_clk);
        rst   = 1'b0;
        i_req = 16'h0201;
        @(negedge i_clk);
        chk_grant("t5_after", 4'd0);

        // 6: requesters 0 and 1, no release
        i_req = 16'h0003;
`ifdef DEC_ARB_TIMEOUT_EN
        for (int c = 1; c < 8; c++) begin
            chk("t6_no_timeout", 32'(o_timeout), 32'h0);
            @(negedge i_clk);
        end
        chk("t6_timeout_pulse", 32'(o_timeout), 32'h1);
        @(negedge i_clk);
        chk_gap("t6", 4'd0);
        chk("t6_timeout_low", 32'(o_timeout), 32'h0);
        @(negedge i_clk);
        chk_grant("t6_next", 4'd1);
`else
        for (int c = 0; c < 100; c++) begin
            chk("t6_hold_valid", 32'(o_gnt_valid), 32'h1);
            chk("t6_hold_idx",   32'(o_gnt_idx),   32'h0);
            chk("t6_timeout",    32'(o_timeout),   32'h0);
            @(negedge i_clk);
        end
        chk_grant("t6_end", 4'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
